// File: rtl/gups_mem_if.sv
// Request/response channel between the gups core (master) and its memory responder (slave).
interface gups_mem_if;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        req;
    logic        wr;
    logic        rdy;
    logic [63:0] rdata;

    modport master (output addr, wdata, req, wr, input rdy, rdata);
    modport slave  (input addr, wdata, req, wr, output rdy, rdata);
endinterface

// File: rtl/gups_mem_resp.sv
// Single-outstanding memory responder for gups: DEPTH x 64-bit array with separate
// read/write latency, preload port, completion counters and a sticky range error.
module gups_mem_resp #(
    parameter int DEPTH  = 8192,
    parameter int AW     = 13,
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 6
) (
    input  logic          clk,
    input  logic          rst,
    gups_mem_if.slave     bus,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [63:0]   init_data,
    output logic          busy,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count,
    output logic          err
);
    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam logic [CW-1:0] RD_CNT = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WR_CNT = CW'(WR_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   cap_idx;
    logic            cap_wr;
    logic            cap_oor;
    logic [63:0]     cap_wdata;
    logic [63:0]     rdata_q;
    logic [63:0]     mem [DEPTH];

    logic            in_oor;
    logic [AW-1:0]   sel_idx;
    logic            sel_wr;
    logic            sel_oor;

    assign in_oor   = |bus.addr[63:AW];
    assign busy     = (state_q != IDLE);
    assign bus.rdy  = (state_q == RESP) && !rst;
    assign bus.rdata = rdata_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel_idx = cap_idx;
        sel_wr  = cap_wr;
        sel_oor = cap_oor;
        case (state_q)
            IDLE: begin
                sel_idx = bus.addr[AW-1:0];
                sel_wr  = bus.wr;
                sel_oor = in_oor;
                if (bus.req)
                    state_d = ((bus.wr ? WR_LAT : RD_LAT) == 1) ? RESP : WAIT;
            end
            WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
            RESP:    state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_idx   <= '0;
            cap_wr    <= 1'b0;
            cap_oor   <= 1'b0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.req) begin
                    cap_idx   <= bus.addr[AW-1:0];
                    cap_wr    <= bus.wr;
                    cap_oor   <= in_oor;
                    cap_wdata <= bus.wdata;
                    cnt_q     <= bus.wr ? WR_CNT : RD_CNT;
                    err       <= err | in_oor;
                end
                WAIT: cnt_q <= cnt_q - CW'(1);
                RESP: begin
                    if (cap_wr) wr_count <= wr_count + 32'd1;
                    else        rd_count <= rd_count + 32'd1;
                end
                default: ;
            endcase
            // Read data is fetched on the edge entering RESP so it is valid with rdy.
            if (state_d == RESP && state_q != RESP && !sel_wr)
                rdata_q <= sel_oor ? '0 : mem[sel_idx];
        end
    end

    // NOTE: the array has no reset; contents survive rst, and rst only gates new writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RESP && cap_wr && !cap_oor)
                mem[cap_idx] <= cap_wdata;
            else if (state_q == IDLE && !bus.req && init_we)
                mem[init_addr] <= init_data;
        end
    end
endmodule

// File: tb/tb_gups_mem_resp.sv
// Directed bench for gups_mem_resp: latency, RMW chain, range errors, collisions and resets.
module tb_gups_mem_resp;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_we;
    logic [12:0] init_addr;
    logic [63:0] init_data;
    logic        busy;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        err;

    gups_mem_if bus();

    gups_mem_resp #(.DEPTH(8192), .AW(13), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .busy      (busy),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    int     n_pass = 0;
    int     n_checks = 0;
    int     extra_rdy = 0;
    int     bad_spacing = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [12:0] idx, input logic [63:0] d);
        init_addr = idx;
        init_data = d;
        init_we   = 1'b1;
        tick;
        init_we   = 1'b0;
    endtask

    // gups-style request: req held through RESP and TURN, dropped once back in IDLE.
    task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                          input bit init_wait, output logic [63:0] rd,
                          output int lat, output longint rdy_cyc);
        bus.addr  = a;
        bus.wr    = w;
        bus.wdata = d;
        bus.req   = 1'b1;
        tick;
        init_we = init_wait;
        lat = 1;
        while (!bus.rdy && lat < 20) begin
            tick;
            lat++;
        end
        if (!bus.rdy) check("rdy_timeout", {63'd0, bus.rdy}, 64'd1);
        rd      = bus.rdata;
        rdy_cyc = cyc;
        init_we = 1'b0;
        tick;
        if (bus.rdy) extra_rdy++;
        tick;
        bus.req = 1'b0;
    endtask

    logic [63:0] rd, v;
    int          lat;
    longint      c, prev;

    initial begin
        rst = 1'b1; init_we = 1'b0; init_addr = '0; init_data = '0;
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) tick;
        check("rst_rdy", {63'd0, bus.rdy}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        check("rst_rd_count", {32'd0, rd_count}, 64'd0);
        check("rst_wr_count", {32'd0, wr_count}, 64'd0);
        rst = 1'b0;
        tick;

        preload(13'd5, 64'h1234_5678_9abc_def0);
        do_req(64'd5, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("rd_lat", 64'(lat), 64'(RD_LAT));
        check("rd_data", rd, 64'h1234_5678_9abc_def0);
        check("rd_count1", {32'd0, rd_count}, 64'd1);

        do_req(64'd8191, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, lat, c);
        check("wr_lat", 64'(lat), 64'(WR_LAT));
        check("wr_count1", {32'd0, wr_count}, 64'd1);
        do_req(64'd8191, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("raw_8191", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset during RESP: rdy masked, write not committed.
        preload(13'd20, 64'hC0C0);
        bus.addr = 64'd20; bus.wr = 1'b1; bus.wdata = 64'hD0D0; bus.req = 1'b1;
        tick;
        repeat (WR_LAT - 1) tick;
        check("resp_rdy", {63'd0, bus.rdy}, 64'd1);
        rst = 1'b1;
        #1;
        check("resp_rst_rdy", {63'd0, bus.rdy}, 64'd0);
        tick;
        rst = 1'b0; bus.req = 1'b0;
        tick;
        check("resp_rst_wr_count", {32'd0, wr_count}, 64'd0);
        do_req(64'd20, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("resp_rst_word", rd, 64'hC0C0);

        // Reset held 3 cycles mid-WAIT of a write.
        preload(13'd10, 64'hAAAA);
        bus.addr = 64'd10; bus.wr = 1'b1; bus.wdata = 64'hBBBB; bus.req = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        repeat (3) tick;
        check("wait_rst_rdy", {63'd0, bus.rdy}, 64'd0);
        check("wait_rst_busy", {63'd0, busy}, 64'd0);
        check("wait_rst_rd_count", {32'd0, rd_count}, 64'd0);
        check("wait_rst_wr_count", {32'd0, wr_count}, 64'd0);
        rst = 1'b0; bus.req = 1'b0;
        tick;
        do_req(64'd10, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("wait_rst_word", rd, 64'hAAAA);

        // RMW chain from fresh counters.
        rst = 1'b1; tick; rst = 1'b0; tick;
        preload(13'd100, 64'd7);
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            do_req(64'd100, 1'b0, 64'd0, 1'b0, v, lat, c);
            if (i > 0 && c - prev != RD_LAT + 2) bad_spacing++;
            prev = c;
            do_req(64'd100, 1'b1, v + 64'd1, 1'b0, rd, lat, c);
            if (c - prev != WR_LAT + 2) bad_spacing++;
            prev = c;
        end
        check("rmw_rd_count", {32'd0, rd_count}, 64'd1000);
        check("rmw_wr_count", {32'd0, wr_count}, 64'd1000);
        check("rmw_spacing", 64'(bad_spacing), 64'd0);
        do_req(64'd100, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("rmw_final", rd, 64'd1007);

        // Collisions: init_we with req in IDLE, and init_we during WAIT.
        preload(13'd201, 64'h5151);
        init_addr = 13'd201; init_data = 64'hDEAD; init_we = 1'b1;
        do_req(64'd200, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("coll_lat", 64'(lat), 64'(RD_LAT));
        do_req(64'd201, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("coll_init_lost", rd, 64'h5151);
        preload(13'd202, 64'h5252);
        init_addr = 13'd202; init_data = 64'hBEEF;
        do_req(64'd300, 1'b0, 64'd0, 1'b1, rd, lat, c);
        do_req(64'd202, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("wait_init_ignored", rd, 64'h5252);
        check("coll_err", {63'd0, err}, 64'd0);
        check("coll_rd_count", {32'd0, rd_count}, 64'd1005);
        check("turn_extra_rdy", 64'(extra_rdy), 64'd0);

        // Out-of-range accesses.
        do_req(64'h2000, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("oor_rd_lat", 64'(lat), 64'(RD_LAT));
        check("oor_rdata", rd, 64'd0);
        check("oor_err", {63'd0, err}, 64'd1);
        preload(13'd0, 64'h0F0F);
        do_req(64'h1_0000_0000, 1'b1, 64'h7777, 1'b0, rd, lat, c);
        do_req(64'd0, 1'b0, 64'd0, 1'b0, rd, lat, c);
        check("oor_wr_dropped", rd, 64'h0F0F);
        check("oor_err_sticky", {63'd0, err}, 64'd1);
        check("oor_rd_count", {32'd0, rd_count}, 64'd1007);
        check("oor_wr_count", {32'd0, wr_count}, 64'd1001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gups_mem_resp.md
Name: gups_mem_resp

Overview:
Memory-side responder that sits directly downstream of the gups core and services its req/wr/rdy read-modify-write traffic.
- Holds a DEPTH x 64-bit word array with independently parameterised read and write latency.
- Runs one outstanding request at a time.
- Provides a preload port and statistics/error outputs, so system benches and FPGA builds run gups without an external memory model.

Parameters:
DEPTH, 8192, number of 64-bit words; power of two.
AW, 13, index width; log2(DEPTH).
RD_LAT, 3, cycles from read acceptance to rdy; must be >= 1.
WR_LAT, 6, cycles from write acceptance to rdy; must be >= 1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
addr  in  64  request word address from gups.
wdata  in  64  write data from gups (gups dout).
req  in  1  request valid; held high by gups until rdy.
wr  in  1  1 = write, 0 = read; qualified by req.
rdy  out  1  one-cycle completion pulse.
rdata  out  64  read data to gups (gups din); valid in the rdy cycle, then held.
init_we  in  1  preload write strobe.
init_addr  in  AW  preload index.
init_data  in  64  preload data.
busy  out  1  high whenever state != IDLE.
rd_count  out  32  completed reads.
wr_count  out  32  completed writes.
err  out  1  sticky out-of-range flag.

Behaviour:
- Reset values:
  - state = IDLE; rdy, busy, err = 0.
  - rdata, rd_count, wr_count = 0.
  - Array contents are not cleared.
- States: IDLE -> WAIT -> RESP -> TURN -> IDLE.
- IDLE:
  - If req = 1, capture addr, wr and wdata into registers.
  - Load the latency counter with RD_LAT or WR_LAT according to wr, then go to WAIT.
  - Else, if init_we = 1, write array[init_addr] = init_data.
  - If req and init_we are high in the same cycle, req wins and init_we is dropped.
- WAIT:
  - Counter decrements each cycle; req, addr, wr and wdata inputs are ignored.
  - Go to RESP so that rdy is high exactly LAT cycles after the acceptance edge. LAT = 1 means rdy is high in the cycle immediately after acceptance.
- RESP (rdy = 1 for this single cycle):
  - Read: rdata = array[captured index], registered so it is valid in this cycle; rd_count increments.
  - Write: array[captured index] = captured wdata, committed at the end of this cycle; wr_count increments.
- TURN: one dead cycle; req is ignored so gups can drop or re-drive req after seeing rdy. Then go to IDLE.
- Back-to-back throughput: one request per LAT + 2 cycles.
- Addressing: index = addr[AW-1:0]. Out-of-range means addr[63:AW] != 0:
  - err is set on acceptance.
  - A read returns rdata = 0.
  - A write is dropped with no array change.
  - rdy is still generated and the counters still increment.
- init_we outside IDLE is ignored, with no array change and no error.
- Counters wrap modulo 2^32.
- Reset mid-operation:
  - Returns to IDLE and drops any pending write, so the array is unchanged.
  - If rst is high in the RESP cycle, rdy is forced to 0 and the write is not committed.
- Read-after-write to the same index returns the newly written value.

Test Plan:
- Reset: hold rst 3 cycles mid-WAIT of a write -> rdy = 0, busy = 0, counters = 0, array word unchanged.
- Read latency: preload [5] = 64'h1234_5678_9abc_def0; req = 1, wr = 0, addr = 5 accepted at edge T -> rdy high only at T+3, rdata = 64'h1234_5678_9abc_def0, rd_count = 1.
- Write latency: req = 1, wr = 1, addr = 8191, wdata = 64'hFFFF_FFFF_FFFF_FFFF at T -> rdy only at T+6, then a read of 8191 returns all-ones, wr_count = 1.
- RMW chain: gups-style read of [100] = 7, then write of 8, repeated 1000 times -> final [100] = 1007, rd_count = wr_count = 1000, each handshake spacing = LAT + 2.
- Out of range: read addr = 64'h2000 -> rdata = 0, err = 1 (stays 1 after later good accesses); write addr = 64'h1_0000_0000 -> no array word changed.
- Collision and turnaround:
  - init_we together with req in IDLE -> the request is served and the init write is lost.
  - init_we in WAIT -> ignored.
  - req held high through TURN -> exactly one completion per request.
